atari_bank_mapper: RTL and testbench

- Parametrised successor to the flat 4 KB cartridge decode of the Atari 2600 system bus.
- Steers CPU read data among cartridge ROM, optional Superchip RAM, RIOT and TIA.
- Implements F8/F6/F4-style hotspot bank switching, so carts up to 32 KB map through the 4 KB cartridge window.
- Sits between the MOS6507 bus and the ROM port; it replaces the combinational CPU_Din mux in the system module.

---
 rtl/atari_bank_mapper.sv | 113 +++++++++++
 tb/tb_atari_bank_mapper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/atari_bank_mapper.sv
// Atari 2600 cartridge bank mapper: F8/F6/F4 hotspot bank switching, optional
// Superchip RAM, and the CPU read-data mux for ROM/RAM/RIOT/TIA.
module atari_bank_mapper #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned BANK_BITS    = 2,
  parameter logic [11:0] HOTSPOT_BASE = 12'hFF6,
  parameter int unsigned RESET_BANK   = 0,
  parameter bit          SC_RAM       = 1'b0
) (
  input  logic                  CLOCKBUS,
  input  logic                  RES,
  input  logic [12:0]           CPU_Addr,
  input  logic                  CPU_R_W_n,
  input  logic [7:0]            CPU_Dout,
  output logic [7:0]            CPU_Din,
  output logic [12+BANK_BITS-1:0] ROM_Addr,
  output logic                  ROM_CS,
  input  logic [7:0]            ROM_Dout,
  input  logic [7:0]            RIOT_Dout,
  input  logic [7:0]            TIA_Dout,
  output logic [BANK_BITS-1:0]  BANK,
  output logic                  HOTSPOT_HIT
);

  localparam logic [12:0] HOT_LO = {1'b0, HOTSPOT_BASE};
  localparam logic [12:0] HOT_HI = HOT_LO + 13'(NUM_BANKS - 1);

  if (NUM_BANKS != 2 && NUM_BANKS != 4 && NUM_BANKS != 8) begin : g_bad_banks
    $error("atari_bank_mapper: NUM_BANKS must be 2, 4 or 8");
  end
  if (BANK_BITS != $clog2(NUM_BANKS)) begin : g_bad_bits
    $error("atari_bank_mapper: BANK_BITS must equal log2(NUM_BANKS)");
  end
  if (RESET_BANK >= NUM_BANKS) begin : g_bad_reset
    $error("atari_bank_mapper: RESET_BANK out of range");
  end

  logic                 cart;
  logic                 sc_wr;
  logic                 sc_rd;
  logic                 hot;
  logic [7:0]           ram_rd;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 hit_q, hit_d;

  // Address decode
  always_comb begin
    cart  = CPU_Addr[12];
    sc_wr = SC_RAM && cart && (CPU_Addr[11:7] == 5'b00000);
    sc_rd = SC_RAM && cart && (CPU_Addr[11:7] == 5'b00001);
    hot   = cart && (13'(CPU_Addr[11:0]) >= HOT_LO) && (13'(CPU_Addr[11:0]) <= HOT_HI);
  end

  // Next bank: hotspot offset from base, taken modulo the bank count
  always_comb begin
    bank_d = bank_q;
    hit_d  = 1'b0;
    if (hot) begin
      bank_d = CPU_Addr[BANK_BITS-1:0] - HOTSPOT_BASE[BANK_BITS-1:0];
      hit_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCKBUS) begin
    if (RES) begin
      bank_q <= BANK_BITS'(RESET_BANK);
      hit_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      hit_q  <= hit_d;
    end
  end

  if (SC_RAM) begin : g_sc_ram
    logic [7:0] ram_q [128];
    logic       ram_we_c;

    always_comb begin
      ram_we_c = sc_wr && !CPU_R_W_n && !RES;
      ram_rd   = ram_q[CPU_Addr[6:0]];
    end

    // Contents survive reset; undefined until first written
    always_ff @(posedge CLOCKBUS) begin
      if (ram_we_c) begin
        ram_q[CPU_Addr[6:0]] <= CPU_Dout;
      end
    end
  end else begin : g_no_ram
    logic unused_wr_bus;
    assign unused_wr_bus = ^{CPU_Dout, CPU_R_W_n};
    assign ram_rd        = 8'h00;
  end

  // Read-data steering and ROM port
  always_comb begin
    if (sc_rd) begin
      CPU_Din = ram_rd;
    end else if (cart) begin
      CPU_Din = ROM_Dout;
    end else if (CPU_Addr[7]) begin
      CPU_Din = RIOT_Dout;
    end else begin
      CPU_Din = TIA_Dout;
    end
    ROM_CS   = cart && !sc_rd && !sc_wr;
    ROM_Addr = {bank_q, CPU_Addr[11:0]};
  end

  assign BANK        = bank_q;
  assign HOTSPOT_HIT = hit_q;

endmodule

// File: tb/tb_atari_bank_mapper.sv
// Directed bench for atari_bank_mapper: F6 defaults, F6 with Superchip RAM,
// and an F4 (8-bank) build, each driven by its own CPU bus.
module tb_atari_bank_mapper;

  logic        clk = 1'b0;
  logic        res;
  logic [7:0]  rom_d  = 8'hC3;
  logic [7:0]  riot_d = 8'h7E;
  logic [7:0]  tia_d  = 8'h81;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // F6 defaults
  logic [12:0] a_addr;
  logic        a_rw;
  logic [7:0]  a_dout, a_din;
  logic [13:0] a_rom_addr;
  logic        a_cs, a_hit;
  logic [1:0]  a_bank;

  // F6 with Superchip RAM
  logic [12:0] b_addr;
  logic        b_rw;
  logic [7:0]  b_dout, b_din;
  logic [13:0] b_rom_addr;
  logic        b_cs, b_hit;
  logic [1:0]  b_bank;

  // F4: eight banks, hotspots 0xFF4-0xFFB
  logic [12:0] c_addr;
  logic        c_rw;
  logic [7:0]  c_dout, c_din;
  logic [14:0] c_rom_addr;
  logic        c_cs, c_hit;
  logic [2:0]  c_bank;

  atari_bank_mapper u_a (
    .CLOCKBUS(clk), .RES(res), .CPU_Addr(a_addr), .CPU_R_W_n(a_rw),
    .CPU_Dout(a_dout), .CPU_Din(a_din), .ROM_Addr(a_rom_addr), .ROM_CS(a_cs),
    .ROM_Dout(rom_d), .RIOT_Dout(riot_d), .TIA_Dout(tia_d),
    .BANK(a_bank), .HOTSPOT_HIT(a_hit)
  );

  atari_bank_mapper #(.SC_RAM(1'b1)) u_b (
    .CLOCKBUS(clk), .RES(res), .CPU_Addr(b_addr), .CPU_R_W_n(b_rw),
    .CPU_Dout(b_dout), .CPU_Din(b_din), .ROM_Addr(b_rom_addr), .ROM_CS(b_cs),
    .ROM_Dout(rom_d), .RIOT_Dout(riot_d), .TIA_Dout(tia_d),
    .BANK(b_bank), .HOTSPOT_HIT(b_hit)
  );

  atari_bank_mapper #(.NUM_BANKS(8), .BANK_BITS(3), .HOTSPOT_BASE(12'hFF4)) u_c (
    .CLOCKBUS(clk), .RES(res), .CPU_Addr(c_addr), .CPU_R_W_n(c_rw),
    .CPU_Dout(c_dout), .CPU_Din(c_din), .ROM_Addr(c_rom_addr), .ROM_CS(c_cs),
    .ROM_Dout(rom_d), .RIOT_Dout(riot_d), .TIA_Dout(tia_d),
    .BANK(c_bank), .HOTSPOT_HIT(c_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one bus edge; land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1;
    a_addr = 13'h1000; a_rw = 1'b1; a_dout = 8'h00;
    b_addr = 13'h1000; b_rw = 1'b1; b_dout = 8'h00;
    c_addr = 13'h1000; c_rw = 1'b1; c_dout = 8'h00;
    tick();
    tick();
    chk("rst_a_bank", 32'(a_bank), 32'h0);
    chk("rst_a_hit",  32'(a_hit),  32'h0);
    chk("rst_c_bank", 32'(c_bank), 32'h0);

    // F6: plain read in bank 0
    res = 1'b0;
    a_addr = 13'h1000;
    #1;
    chk("a_rd1000_romaddr", 32'(a_rom_addr), 32'h0000);
    chk("a_rd1000_din",     32'(a_din),      32'hC3);
    chk("a_rd1000_cs",      32'(a_cs),       32'h1);
    tick();
    chk("a_rd1000_bank", 32'(a_bank), 32'h0);
    chk("a_rd1000_hit",  32'(a_hit),  32'h0);

    // F6: hotspot 0xFF8 -> bank 2, old bank seen during the access
    a_addr = 13'h1FF8;
    #1;
    chk("a_hot8_oldbank", 32'(a_rom_addr), 32'h0FF8);
    tick();
    chk("a_hot8_bank", 32'(a_bank), 32'h2);
    chk("a_hot8_hit",  32'(a_hit),  32'h1);
    #1;
    chk("a_hot8_repeat_newbank", 32'(a_rom_addr), 32'h2FF8);
    tick();
    chk("a_hot8_repeat_hit",  32'(a_hit),  32'h1);
    chk("a_hot8_repeat_bank", 32'(a_bank), 32'h2);

    a_addr = 13'h1123;
    #1;
    chk("a_rd1123_romaddr", 32'(a_rom_addr), 32'h2123);
    tick();
    chk("a_rd1123_hit",  32'(a_hit),  32'h0);
    chk("a_rd1123_bank", 32'(a_bank), 32'h2);

    // F6: hotspot write switches too
    a_addr = 13'h1FF9; a_rw = 1'b0;
    tick();
    chk("a_wr9_bank", 32'(a_bank), 32'h3);
    chk("a_wr9_hit",  32'(a_hit),  32'h1);

    // Reset beats a simultaneous hotspot access
    res = 1'b1; a_addr = 13'h1FF6; a_rw = 1'b1;
    tick();
    chk("a_res_hot6_bank", 32'(a_bank), 32'h0);
    chk("a_res_hot6_hit",  32'(a_hit),  32'h0);
    res = 1'b0; a_addr = 13'h1FF7;
    tick();
    chk("a_hot7_bank", 32'(a_bank), 32'h1);
    res = 1'b1; a_addr = 13'h1FF8;
    tick();
    chk("a_res_hot8_bank", 32'(a_bank), 32'h0);
    chk("a_res_hot8_hit",  32'(a_hit),  32'h0);

    // Non-cart addresses: mirrors of hotspots do nothing; RIOT vs TIA on A7
    res = 1'b0; a_addr = 13'h0FF8;
    #1;
    chk("a_0ff8_din", 32'(a_din), 32'h7E);
    chk("a_0ff8_cs",  32'(a_cs),  32'h0);
    tick();
    chk("a_0ff8_bank", 32'(a_bank), 32'h0);
    chk("a_0ff8_hit",  32'(a_hit),  32'h0);
    a_addr = 13'h0280;
    #1;
    chk("a_0280_din", 32'(a_din), 32'h7E);
    chk("a_0280_cs",  32'(a_cs),  32'h0);
    tick();
    a_addr = 13'h0F78;
    #1;
    chk("a_0f78_din", 32'(a_din), 32'h81);
    chk("a_0f78_cs",  32'(a_cs),  32'h0);
    tick();
    chk("a_0f78_bank", 32'(a_bank), 32'h0);
    a_addr = 13'h1000;

    // Superchip: write window, read window, boundaries
    b_addr = 13'h1005; b_rw = 1'b0; b_dout = 8'hA5;
    #1;
    chk("b_wr05_cs", 32'(b_cs), 32'h0);
    tick();
    b_addr = 13'h107F; b_dout = 8'h3C;
    tick();
    b_addr = 13'h1085; b_rw = 1'b1;
    #1;
    chk("b_rd85_din", 32'(b_din), 32'hA5);
    chk("b_rd85_cs",  32'(b_cs),  32'h0);
    tick();
    b_addr = 13'h10FF;
    #1;
    chk("b_rdff_din", 32'(b_din), 32'h3C);
    tick();
    b_addr = 13'h1005;
    #1;
    chk("b_rd05_din", 32'(b_din), 32'hC3);
    chk("b_rd05_cs",  32'(b_cs),  32'h0);
    tick();
    b_addr = 13'h1085;
    #1;
    chk("b_rd85_after_rd05", 32'(b_din), 32'hA5);
    b_rw = 1'b0; b_dout = 8'h5A;
    tick();
    b_rw = 1'b1;
    #1;
    chk("b_rd85_after_wr85", 32'(b_din), 32'hA5);
    tick();
    res = 1'b1; b_addr = 13'h1005; b_rw = 1'b0; b_dout = 8'h77;
    tick();
    res = 1'b0; b_addr = 13'h1085; b_rw = 1'b1;
    #1;
    chk("b_rd85_after_res_wr", 32'(b_din), 32'hA5);
    tick();
    b_addr = 13'h1100;
    #1;
    chk("b_rd100_cs",  32'(b_cs),  32'h1);
    chk("b_rd100_din", 32'(b_din), 32'hC3);
    tick();
    b_addr = 13'h1FF9;
    tick();
    chk("b_hot9_bank", 32'(b_bank), 32'h3);
    b_addr = 13'h1000;

    // F4: top hotspot, out-of-range neighbours, bottom hotspot
    c_addr = 13'h1FFB;
    #1;
    chk("c_hotb_oldbank", 32'(c_rom_addr), 32'h0FFB);
    tick();
    chk("c_hotb_bank", 32'(c_bank), 32'h7);
    chk("c_hotb_hit",  32'(c_hit),  32'h1);
    c_addr = 13'h1000;
    #1;
    chk("c_rd1000_romaddr", 32'(c_rom_addr), 32'h7000);
    tick();
    chk("c_rd1000_hit", 32'(c_hit), 32'h0);
    c_addr = 13'h1FFC;
    tick();
    chk("c_ffc_bank", 32'(c_bank), 32'h7);
    chk("c_ffc_hit",  32'(c_hit),  32'h0);
    c_addr = 13'h1FF3;
    tick();
    chk("c_ff3_bank", 32'(c_bank), 32'h7);
    chk("c_ff3_hit",  32'(c_hit),  32'h0);
    c_addr = 13'h1FF4;
    tick();
    chk("c_ff4_bank", 32'(c_bank), 32'h0);
    chk("c_ff4_hit",  32'(c_hit),  32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
